data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Multi-cycle data memory that answers load/store requests from the pipelined CPU's MEM stage over a request/acknowledge handshake. It models a slow memory with fixed access latency. It raises `busy_o` so the CPU can stall its pipeline until `ack_o` returns data or confirms the write. It replaces the zero-latency data memory on the CPU side of the MEM stage.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words in the array.
- `LATENCY`, 4: cycles from request acceptance to `ack_o`; legal range is 2 or more.

Ports:
- `clk_i`, in, 1: the only clock; all logic is on the rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `req_i`, in, 1: request valid (level); sampled only in IDLE.
- `we_i`, in, 1: 1 = store, 0 = load; sampled with `req_i`.
- `addr_i`, in, 32: byte address; sampled with `req_i`.
- `wdata_i`, in, 32: store data; sampled with `req_i`.
- `busy_o`, out, 1: a request is in flight; the CPU stalls while this is high.
- `ack_o`, out, 1: one-cycle completion pulse.
- `rdata_o`, out, 32: load result; valid in the `ack_o` cycle and held until the next `ack_o`.
- `err_o`, out, 1: access error, pulsed together with `ack_o`.

## Operation
States and transitions:
- IDLE: if `req_i`=1, latch `we_i`, `addr_i` and `wdata_i`, load the counter with LATENCY-1, and go to BUSY. Otherwise stay in IDLE.
- BUSY: decrement the counter each cycle. When the counter reaches 0, go to ACK.
- ACK: `ack_o`=1 for exactly one cycle, then return to IDLE.

Outputs:
- `busy_o` is registered and high exactly in BUSY and ACK.

Commit and read:
- The store commits, and load data is captured into `rdata_o`, on the same edge that enters ACK.
- Word index is `addr[$clog2(DEPTH)+1:2]`.

Errors:
- An error is `addr[1:0]` not equal to 0, or `addr[31:2]` greater than or equal to DEPTH.
- On error: no array write; `rdata_o` is set to 0; `err_o`=1 in the ACK cycle.
- In all other cycles `err_o`=0.

Request rules:
- `req_i` is ignored in BUSY and ACK; there is no queueing.
- The requester drops or changes `req_i` before the cycle after `ack_o`. If `req_i` is still high in the IDLE cycle after ACK, it is taken as a new request.

Arithmetic:
- The counter is `$clog2(LATENCY)` bits and never wraps. It is only decremented from a value greater than 0.

Reset:
- State goes to IDLE, the counter to 0, and `busy_o`, `ack_o`, `err_o` and `rdata_o` to 0.
- Array contents are not reset; they are preloaded by the bench via hierarchy.
- Reset in BUSY aborts the access: no write and no `ack_o`.
- Reset in the same cycle as `req_i` wins; the request is dropped.

## Timing
- A request sampled at edge T gives `busy_o`=1 from T+1 through T+LATENCY.
- `ack_o`, `rdata_o` and `err_o` are valid in cycle T+LATENCY.
- Store data is visible to a load accepted at any edge after the store's ACK edge.
- The minimum spacing between two accepted requests is LATENCY+1 cycles, which gives a throughput of one access per LATENCY+1 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
Shared package `dmem_pkg`:
- State enum {IDLE, BUSY, ACK}.
- Default LATENCY and DEPTH constants.
- Error-check address widths.

Sub-module `dmem_array`:
- Single-port word array, DEPTH by 32.
- Synchronous write enable; read captured on the same edge as the write.

The top level holds the FSM, the latency counter, the request latches and the error decode.

## Test plan
All scenarios use LATENCY=4.

- **Basic load:** preload word 3 = 0xDEADBEEF; `req_i`=1, `we_i`=0, `addr_i`=0x0C for 1 cycle at T. Expect `busy_o` high for T+1 to T+4, `ack_o` pulse at T+4, `rdata_o`=0xDEADBEEF, `err_o`=0.
- **Store then load:** store 0x12345678 to 0x40, then load 0x40 in the first IDLE cycle after ACK. Expect the second ACK to return 0x12345678; no other word changes.
- **Misaligned and out of range:** load at 0x41, then store at 0x400 with DEPTH=256. Expect each ACK to have `err_o`=1 and `rdata_o`=0; word 0 unchanged after the store.
- **Request held high:** hold `req_i` high continuously with a load at 0x0C. Expect ACKs every 5 cycles, and requests during BUSY and ACK not double-counted.
- **Reset mid-operation:** store 0xFFFFFFFF to 0x10; assert `rst_i` at T+2. Expect all outputs 0 from the next edge, no `ack_o`, word 4 unchanged.
- **Back-to-back mix:** run 20 random aligned loads and stores against a reference model. Expect every `rdata_o` to match the model; `busy_o` never low between acceptance and ACK.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, defaults and address error decode for the data memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;
  localparam int DEF_DEPTH = 256;
  localparam int DEF_LATENCY = 4;
  localparam int ADDR_W = 32;
  function automatic logic addr_err(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[ADDR_W-1:2]} >= depth);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x 32 word array with read and write on the same enabled edge
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     we,
  input  logic                     clr,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];
  // storage is never reset; contents come from preload or committed stores
  always_ff @(posedge clk)
    if (en && we) mem[idx] <= wdata;
  // load result is captured on the commit edge, forced to zero for faulting accesses
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (en && (!we || clr)) rdata <= clr ? '0 : mem[idx];
endmodule

// File: rtl/data_memory_responder.sv
// data_memory_responder: fixed-latency load/store memory behind a req/ack handshake
module data_memory_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int LATENCY = DEF_LATENCY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);
  localparam int CW = $clog2(LATENCY);
  localparam int IW = $clog2(DEPTH);
  state_t state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic we_q;
  logic [31:0] addr_q, wdata_q;
  logic err, commit;
  assign err = addr_err(addr_q, DEPTH);
  // the edge leaving the last BUSY cycle enters ACK; a reset on that edge suppresses the write
  assign commit = (state == BUSY) && (cnt == CW'(1)) && !rst_i;
  // next state and latency countdown; the counter only moves while BUSY and stops at zero
  always_comb begin
    state_next = state;
    cnt_next = cnt;
    case (state)
      IDLE: if (req_i) begin
        state_next = BUSY;
        cnt_next = CW'(LATENCY - 1);
      end
      BUSY: begin
        cnt_next = cnt - 1'b1;
        state_next = (cnt == CW'(1)) ? ACK : BUSY;
      end
      ACK: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end
  // state, counter and registered handshake outputs
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      cnt <= '0;
      busy_o <= 1'b0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      state <= state_next;
      cnt <= cnt_next;
      busy_o <= state_next != IDLE;
      ack_o <= commit;
      err_o <= commit && err;
    end
  // request fields are captured only when a request is accepted from IDLE
  always_ff @(posedge clk_i)
    if (state == IDLE && req_i) begin
      we_q <= we_i;
      addr_q <= addr_i;
      wdata_q <= wdata_i;
    end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk  (clk_i),
    .rst  (rst_i),
    .en   (commit),
    .we   (we_q && !err),
    .clr  (err),
    .idx  (addr_q[IW+1:2]),
    .wdata(wdata_q),
    .rdata(rdata_o)
  );
endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder: randomized scoreboard bench against a word-array reference model
module tb_data_memory_responder;
  localparam int DEPTH = 256;
  localparam int LATENCY = 4;
  logic clk_i = 0, rst_i = 1, req_i = 0, we_i = 0;
  logic [31:0] addr_i = 0, wdata_i = 0;
  logic busy_o, ack_o, err_o;
  logic [31:0] rdata_o;
  typedef struct {logic ld; logic err; logic [31:0] data; time t;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [31:0] ref_mem [DEPTH];
  int total = 0, bad = 0;
  bit mon_on = 0;

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .busy_o(busy_o), .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic is_err(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  // reference model: a plain word array updated in request order
  task automatic accept(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t x;
    int unsigned wi;
    wi = (a / 4) % DEPTH;
    x.ld = !w;
    x.err = is_err(a);
    x.data = x.err ? 32'h0 : ref_mem[wi];
    if (w && !x.err) ref_mem[wi] = d;
    x.t = $time;
    q.push_back(x);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk_i);
    while (busy_o !== 1'b0 && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 50) chk("idle_timeout", {31'b0, busy_o}, 32'h0);
  endtask

  task automatic req1(input logic w, input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    req_i = 1; we_i = w; addr_i = a; wdata_i = d;
    @(posedge clk_i);
    accept(w, a, d);
    @(negedge clk_i);
    req_i = 0;
  endtask

  // monitor: pops one expectation per ack and checks latency, data and busy coverage
  always @(negedge clk_i)
    if (mon_on) begin
      if (ack_o === 1'b1) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ack=1 expected no ack at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("ack_latency", 32'($time - e.t), 32'((LATENCY - 1) * 10 + 5));
          chk("ack_busy", {31'b0, busy_o}, 32'h1);
          chk("ack_err", {31'b0, err_o}, {31'b0, e.err});
          if (e.ld || e.err) chk("ack_rdata", rdata_o, e.data);
        end
      end else begin
        if (q.size() > 0) chk("busy_in_flight", {31'b0, busy_o}, 32'h1);
        chk("err_no_ack", {31'b0, err_o}, 32'h0);
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = $urandom;
      dut.u_array.mem[i] = ref_mem[i];
    end
    ref_mem[3] = 32'hDEADBEEF;
    dut.u_array.mem[3] = 32'hDEADBEEF;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_busy", {31'b0, busy_o}, 32'h0);
    chk("rst_ack", {31'b0, ack_o}, 32'h0);
    chk("rst_err", {31'b0, err_o}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    rst_i = 0;
    mon_on = 1;
    req1(0, 32'h0C, 0);
    req1(1, 32'h40, 32'h12345678);
    req1(0, 32'h40, 0);
    req1(0, 32'h41, 0);
    req1(1, 32'h400, 32'hCAFEF00D);
    req1(0, 32'h0, 0);
    wait_idle();
    req_i = 1; we_i = 0; addr_i = 32'h0C; wdata_i = 0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) repeat (4) @(posedge clk_i);
      @(posedge clk_i);
      accept(0, 32'h0C, 0);
    end
    @(negedge clk_i);
    req_i = 0;
    wait_idle();
    req_i = 1; we_i = 1; addr_i = 32'h10; wdata_i = 32'hFFFFFFFF;
    @(posedge clk_i);
    @(negedge clk_i);
    req_i = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1;
    @(posedge clk_i);
    @(negedge clk_i);
    chk("midrst_busy", {31'b0, busy_o}, 32'h0);
    chk("midrst_ack", {31'b0, ack_o}, 32'h0);
    chk("midrst_err", {31'b0, err_o}, 32'h0);
    chk("midrst_rdata", rdata_o, 32'h0);
    rst_i = 0;
    repeat (6) @(negedge clk_i);
    req1(0, 32'h10, 0);
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      req1(1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH - 1)) << 2, $urandom);
    end
    begin
      int n = 0;
      while (q.size() > 0 && n < 50) begin
        @(negedge clk_i);
        n++;
      end
      chk("drain", 32'(q.size()), 32'h0);
    end
    for (int i = 0; i < DEPTH; i++) chk("mem_word", dut.u_array.mem[i], ref_mem[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
